data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter NCH, default 5, number of requesting cores (main + SUBCORE_NUM subcores), legal 2..8.
REQ-002 Parameter AW, default 32, word-address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter RD_LAT, default 2, data-memory read latency in cycles from mem_en to mem_dout valid, legal 1..4.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  NCH  per-channel request valid.
REQ-008 req_addr  input  NCH*AW  per-channel address, channel i at bits [i*AW +: AW].
REQ-009 req_din  input  NCH*DW  per-channel write data.
REQ-010 req_we  input  NCH*4  per-channel byte write enables; all-zero means read.
REQ-011 req_ready  output  NCH  one-hot-or-zero grant; request accepted when req_valid[i] and req_ready[i] are both high.
REQ-012 rsp_valid  output  NCH  one-cycle read-response strobe per channel.
REQ-013 rsp_dout  output  DW  read data, valid while any rsp_valid bit is high.
REQ-014 mem_en, mem_addr, mem_din, mem_we  output  1/AW/DW/4  registered memory port.
REQ-015 mem_dout  input  DW  memory read data.

Function
REQ-016 At most one channel SHALL be granted per cycle; req_ready SHALL be a combinational function of req_valid, the pointer and the pending flags.
REQ-017 Eligible[i] = req_valid[i] & (~pending[i] | rsp_valid_next[i]); a channel with an outstanding read SHALL NOT be granted until the cycle its response is delivered.
REQ-018 Round-robin: search starts at ptr (reset 0) and proceeds upward with wrap; after a grant to i, ptr = (i+1) mod NCH; ptr SHALL be unchanged in cycles without a grant.
REQ-019 A grant in cycle t SHALL drive mem_en=1 and the granted addr/din/we onto mem_* in cycle t+1; mem_en=0 and mem_we=0 in cycles following no grant.
REQ-020 Write grants (we!=0) SHALL produce no response and set no pending flag; back-to-back writes from one channel are permitted.
REQ-021 A read grant to channel i SHALL set pending[i]; rsp_valid[i] SHALL pulse exactly RD_LAT cycles after its mem_en cycle, with rsp_dout = mem_dout in that cycle, and SHALL clear pending[i].
REQ-022 The response pipeline SHALL be an RD_LAT-deep shift register of {valid, channel id}; responses SHALL emerge in grant order, at most one per cycle.
REQ-023 A response to channel i and a new grant to channel i in the same cycle SHALL both occur.
REQ-024 With no eligible channel, req_ready SHALL be all-zero.

Reset
REQ-025 On rst: ptr=0, pending=0, response pipeline invalid; req_ready, rsp_valid, mem_en, mem_we SHALL be 0, rsp_dout, mem_addr, mem_din SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight reads; no rsp_valid SHALL pulse for reads granted before reset.

Configuration
REQ-027 Macro DMEM_MAIN_PRIORITY_EN defined: channel 0 SHALL win whenever eligible; round-robin per REQ-018 applies among channels 1..NCH-1 only, and ptr SHALL NOT advance on a channel-0 grant.
REQ-028 Macro undefined: pure round-robin over all NCH channels per REQ-018.

Verification
REQ-029 Reset, then all five channels read continuously -> grants 0,1,2,3,4,0,... (macro off); each rsp_valid[i] RD_LAT+1 cycles after grant.
REQ-030 Channel 2 reads addr 0x10 after write 0xDEADBEEF, we=4'b1111 -> rsp_dout=0xDEADBEEF on rsp_valid[2], no response for the write.
REQ-031 Channel 1 holds req_valid with a read pending, RD_LAT=2 -> req_ready[1] low for 2 cycles, regranted in the response cycle.
REQ-032 Macro on, channels 0 and 3 valid every cycle with writes -> channel 0 granted every cycle, channel 3 never.
REQ-033 Read granted to channel 4, rst pulsed the next cycle -> all outputs 0, no rsp_valid afterwards, ptr=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Request/response lanes of NCH cores plus the shared registered data-memory port.
// The arbiter takes the slave side; requesters and memory together form the master side.
interface data_mem_arbiter_if #(
  parameter int NCH = 5,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req_valid;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_din;
  logic [NCH*4-1:0]  req_we;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_dout;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [3:0]        mem_we;
  logic [DW-1:0]     mem_dout;

  modport slave (
    input  req_valid, req_addr, req_din, req_we, mem_dout,
    output req_ready, rsp_valid, rsp_dout, mem_en, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_addr, req_din, req_we, mem_dout,
    input  req_ready, rsp_valid, rsp_dout, mem_en, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter of NCH cores onto one registered memory port (grant -> mem_en +1, read rsp +RD_LAT+1);
// a core with a read in flight is held off until its response cycle. Optional DMEM_MAIN_PRIORITY_EN: core 0 always wins.
module data_mem_arbiter #(
  parameter int NCH    = 5,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);
  localparam int PW = $clog2(NCH);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic              mem_en_q, mem_rd_q;
  logic [PW-1:0]     mem_id_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_din_q;
  logic [3:0]        mem_we_q;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [PW-1:0]     pipe_id_q [RD_LAT];
  logic [PW-1:0]     pipe_id_d [RD_LAT];

  logic [NCH-1:0] eligible, rsp_vld, gnt_oh;
  logic           gnt_found, gnt_rd;
  logic [PW-1:0]  gnt_idx;
  logic [AW-1:0]  gnt_addr;
  logic [DW-1:0]  gnt_din;
  logic [3:0]     gnt_we;

  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pipe_vld_q[RD_LAT-1] && pipe_id_q[RD_LAT-1] == PW'(i)) rsp_vld[i] = 1'b1;
    end
  end

  // The response cycle itself frees the channel, so a waiting core is regranted back-to-back.
  assign eligible = bus.req_valid & (~pending_q | rsp_vld);

  always_comb begin : arb_c
    int           cand;
    logic [PW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef DMEM_MAIN_PRIORITY_EN
    if (eligible[0]) gnt_found = 1'b1;
`endif
    for (int k = 0; k < NCH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = PW'(cand);
`ifdef DMEM_MAIN_PRIORITY_EN
      if (!gnt_found && cand_idx != '0 && eligible[cand_idx]) begin
`else
      if (!gnt_found && eligible[cand_idx]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef DMEM_MAIN_PRIORITY_EN
    if (gnt_found && gnt_idx != '0) begin
`else
    if (gnt_found) begin
`endif
      ptr_d = (gnt_idx == PW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    gnt_oh   = '0;
    gnt_addr = '0;
    gnt_din  = '0;
    gnt_we   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_oh[i] = gnt_found && !rst;
        gnt_addr  = bus.req_addr[i*AW +: AW];
        gnt_din   = bus.req_din[i*DW +: DW];
        gnt_we    = bus.req_we[i*4 +: 4];
      end
    end
  end

  assign gnt_rd    = (gnt_we == 4'b0000);
  assign pending_d = (pending_q & ~rsp_vld) | (gnt_rd ? gnt_oh : '0);

  // Reads enter the id pipe in their mem_en cycle, so the last stage lines up with mem_dout.
  always_comb begin
    pipe_vld_d[0] = mem_rd_q;
    pipe_id_d[0]  = mem_id_q;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_id_d[s]  = pipe_id_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      pending_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_id_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= '0;
      pipe_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_id_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      mem_en_q   <= gnt_found;
      mem_rd_q   <= gnt_found && gnt_rd;
      mem_we_q   <= gnt_found ? gnt_we : 4'b0000;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
      if (gnt_found) begin
        mem_id_q   <= gnt_idx;
        mem_addr_q <= gnt_addr;
        mem_din_q  <= gnt_din;
      end
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_dout  = (|rsp_vld) ? bus.mem_dout : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: RD_LAT-cycle memory model, read scoreboard checked on rsp_valid.
// Grant sequences that depend on DMEM_MAIN_PRIORITY_EN are selected at compile time.
module tb_data_mem_arbiter;
  localparam int NCH = 5, AW = 32, DW = 32, RD_LAT = 2;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  data_mem_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();
  data_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0, cyc = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [NCH-1:0] mon_oh;
  logic [NCH-1:0] ch_vld;
  logic [31:0] ch_addr [NCH];
  logic [31:0] ch_din  [NCH];
  logic [3:0]  ch_we   [NCH];
  logic [31:0] ref_mem [256];
  logic [31:0] env_mem [256];
  logic [255:0] env_wr = '0;
  logic [31:0] rd_pipe [RD_LAT];
  logic        prev_en;
  logic [31:0] prev_addr, prev_din;
  logic [3:0]  prev_we;
  int          rr_seq [10];
  int          pri_seq [4];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] env_rd(input logic [7:0] a);
    return env_wr[a] ? env_mem[a] : init_word({24'h0, a});
  endfunction

  // Memory model: writes land at the mem_en edge, read data appears RD_LAT cycles after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we != 4'b0000) begin
      env_mem[bus.mem_addr[7:0]] <= merge(env_rd(bus.mem_addr[7:0]), bus.mem_din, bus.mem_we);
      env_wr[bus.mem_addr[7:0]]  <= 1'b1;
    end
    rd_pipe[0] <= env_rd(bus.mem_addr[7:0]);
    for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bus.mem_dout = rd_pipe[RD_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setch(input int ch, input logic vld, input logic [31:0] addr, input logic [31:0] din, input logic [3:0] we);
    ch_vld[ch]  = vld;
    ch_addr[ch] = addr;
    ch_din[ch]  = din;
    ch_we[ch]   = we;
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      bus.req_valid[i]           = ch_vld[i];
      bus.req_addr[i*AW +: AW]   = ch_addr[i];
      bus.req_din[i*DW +: DW]    = ch_din[i];
      bus.req_we[i*4 +: 4]       = ch_we[i];
    end
  endtask

  // One cycle: drive, check grant and last cycle's memory command, then advance.
  task automatic tick(input int exp_g);
    logic [NCH-1:0] exp_rdy;
    logic [7:0]     a;
    drive();
    #1;
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("mem_en", bus.mem_en, prev_en);
    chk("mem_we", bus.mem_we, prev_en ? prev_we : 4'b0000);
    if (prev_en) begin
      chk("mem_addr", bus.mem_addr, prev_addr);
      chk("mem_din", bus.mem_din, prev_din);
    end
    prev_en = (exp_g >= 0);
    if (exp_g >= 0) begin
      prev_addr = ch_addr[exp_g];
      prev_din  = ch_din[exp_g];
      prev_we   = ch_we[exp_g];
      a         = ch_addr[exp_g][7:0];
      if (ch_we[exp_g] == 4'b0000) sb.push_back('{exp_g, ref_mem[a], cyc + RD_LAT + 1});
      else ref_mem[a] = merge(ref_mem[a], ch_din[exp_g], ch_we[exp_g]);
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    #3;
    if (!rst && bus.rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        mon_e  = sb.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.ch] = 1'b1;
        chk("rsp_valid", bus.rsp_valid, mon_oh);
        chk("rsp_dout", bus.rsp_dout, mon_e.data);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
`ifdef DMEM_MAIN_PRIORITY_EN
    rr_seq  = '{0, 1, 2, 0, 3, 4, 0, 1, 2, 0};
    pri_seq = '{0, 0, 0, 0};
`else
    rr_seq  = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    pri_seq = '{3, 0, 3, 0};
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < NCH; i++) setch(i, 1'b1, 32'h40 + i, 32'hA000_0000 | i, 4'b0000);
    prev_en = 1'b0; prev_addr = '0; prev_din = '0; prev_we = '0;
    rst = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_dout", bus.rsp_dout, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    ch_vld = '0;
    drive();
    @(negedge clk);
    #1;
    rst = 1'b0;

    // All five cores reading continuously.
    ch_vld = '1;
    for (int n = 0; n < 10; n++) tick(rr_seq[n]);
    ch_vld = '0;
    repeat (3) tick(-1);

    // Core 2: full write, back-to-back partial write, read-back of both.
    setch(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111); tick(2);
    setch(2, 1'b1, 32'h14, 32'h1234_5678, 4'b0011); tick(2);
    setch(2, 1'b1, 32'h10, 32'h0, 4'b0000);         tick(2);
    ch_vld = '0;
    repeat (3) tick(-1);
    setch(2, 1'b1, 32'h14, 32'h0, 4'b0000);         tick(2);
    ch_vld = '0;
    repeat (3) tick(-1);

    // Core 1 holds its read request: blocked while pending, regranted in its response cycle.
    setch(1, 1'b1, 32'h20, 32'h0, 4'b0000);
    tick(1); tick(-1); tick(-1); tick(1);
    ch_vld = '0;
    repeat (3) tick(-1);

    // Cores 0 and 3 writing every cycle.
    setch(0, 1'b1, 32'h30, 32'h0000_00AA, 4'b0001);
    setch(3, 1'b1, 32'h33, 32'hBB00_0000, 4'b1000);
    for (int n = 0; n < 4; n++) tick(pri_seq[n]);
    ch_vld = '0;
    tick(-1);

    // Read to core 4, then reset the following cycle: the read must vanish.
    setch(4, 1'b1, 32'h44, 32'h0, 4'b0000);
    tick(4);
    ch_vld = '0;
    rst = 1'b1;
    drive();
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_rsp_dout", bus.rsp_dout, 0);
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_mem_we", bus.mem_we, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_mem_din", bus.mem_din, 0);
    sb.delete();
    prev_en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick(-1);
    for (int i = 0; i < NCH; i++) setch(i, 1'b1, 32'h50 + i, 32'h0, 4'b0000);
    tick(0);
    ch_vld = '0;
    ch_vld[4] = 1'b1;
    tick(4);
    ch_vld = '0;
    repeat (4) tick(-1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
